// File: rtl/sign_narrow_unit.sv
// rtl/sign_narrow_unit.sv - IN_W to OUT_W signed narrowing unit with overflow flag, 2-entry output FIFO, saturating overflow counter
// Optional: define SIGN_NARROW_SATURATE_EN to clamp overflowing words instead of truncating them.
module sign_narrow_unit #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clear_count,
  output logic [15:0]      ovf_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IN_W-OUT_W:0] w_upper;
  logic                w_ovf;
  logic [OUT_W-1:0]    w_narrow;
  logic [OUT_W:0]      w_entry;
  logic                w_push;
  logic                w_pop;
  logic                w_load_head_in;
  logic                w_load_head_tail;
  logic                w_load_tail;

  logic [OUT_W:0]      r_head;
  logic [OUT_W:0]      r_tail;
  logic [15:0]         r_ovf_count;

  // The word survives a round trip only if the dropped bits plus the new sign bit all agree.
  assign w_upper = in_data[IN_W-1:OUT_W-1];
  assign w_ovf   = ~((&w_upper) | ~(|w_upper));

`ifdef SIGN_NARROW_SATURATE_EN
  assign w_narrow = !w_ovf          ? in_data[OUT_W-1:0] :
                    in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                      {1'b0, {(OUT_W-1){1'b1}}};
`else
  assign w_narrow = in_data[OUT_W-1:0];
`endif

  assign w_entry   = {w_ovf, w_narrow};
  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_tail = 1'b0;
    w_load_tail      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt    = S_ONE;
          w_load_head_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          w_load_head_in = 1'b1;
        end else if (w_push) begin
          w_state_nxt = S_FULL;
          w_load_tail = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt      = S_ONE;
          w_load_head_tail = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Head is the output register; the tail slot only ever feeds the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (w_load_head_in) begin
      r_head <= w_entry;
    end else if (w_load_head_tail) begin
      r_head <= r_tail;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_tail) begin
      r_tail <= w_entry;
    end
  end

  assign out_data = r_head[OUT_W-1:0];
  assign out_ovf  = r_head[OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (clear_count) begin
      r_ovf_count <= '0;
    end else if (w_push && w_ovf && (r_ovf_count != 16'hFFFF)) begin
      r_ovf_count <= r_ovf_count + 16'd1;
    end
  end

  assign ovf_count = r_ovf_count;

endmodule
